// File: rtl/imm_pkg.sv
// Shared decode vocabulary: RV opcode constants, immediate format tag and the
// decoder result record (immediate always carried at 64 bits, users truncate).
package imm_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    logic [63:0] imm;
    imm_fmt_e    fmt;
    logic        illegal;
  } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder. Immediates are sign/zero-extended to 64 bits;
// truncating to 32 bits yields the correct RV32 value, so only shamt width and
// the word-op legality depend on XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr_i,
  output imm_res_t    res_o
);

  logic [6:0] opc;
  logic       is_shift;

  assign opc      = instr_i[6:0];
  assign is_shift = (instr_i[13:12] == 2'b01);

  always_comb begin
    res_o = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        res_o.imm = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
        res_o.fmt = FMT_U;
      end
      OPC_JAL: begin
        res_o.imm = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        res_o.fmt = FMT_J;
      end
      OPC_JALR, OPC_LOAD: begin
        res_o.imm = {{52{instr_i[31]}}, instr_i[31:20]};
        res_o.fmt = FMT_I;
      end
      OPC_OPIMM: begin
        if (is_shift) begin
          // funct7 (incl. the srai/srli select bit) never leaks into the shamt
          res_o.imm = (XLEN == 64) ? {58'b0, instr_i[25:20]} : {59'b0, instr_i[24:20]};
          res_o.fmt = FMT_SH;
        end else begin
          res_o.imm = {{52{instr_i[31]}}, instr_i[31:20]};
          res_o.fmt = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (XLEN != 64) begin
          res_o.illegal = 1'b1;
        end else if (is_shift) begin
          res_o.imm = {59'b0, instr_i[24:20]};
          res_o.fmt = FMT_SH;
        end else begin
          res_o.imm = {{52{instr_i[31]}}, instr_i[31:20]};
          res_o.fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        res_o.imm = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        res_o.fmt = FMT_S;
      end
      OPC_BRANCH: begin
        res_o.imm = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        res_o.fmt = FMT_B;
      end
      OPC_OP, OPC_MISCMEM, OPC_SYSTEM: ;
      OPC_OP32: res_o.illegal = (XLEN != 64);
      default:  res_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decoder feeding an output register (O)
// backed by a skid register (S), plus a saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_imm,
  output imm_fmt_e             out_fmt,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt,
  input  logic                 ill_cnt_clr
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } slot_t;

  localparam logic [ILL_CNT_W-1:0] CNT_MAX = '1;

  imm_res_t              dec_res;
  slot_t                 new_slot;
  slot_t                 o_q, o_d, s_q, s_d;
  logic                  o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic [ILL_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  accept;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (in_instr),
    .res_o   (dec_res)
  );

  assign new_slot = '{instr: in_instr, imm: dec_res.imm[XLEN-1:0],
                      fmt: dec_res.fmt, illegal: dec_res.illegal};

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a held valid keeps its payload stable until that edge.
  assign in_ready = !s_valid_q && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (out_ready && s_valid_q) begin
      o_d       = s_q;
      o_valid_d = 1'b1;
      s_valid_d = 1'b0;
    end else if (accept) begin
      if (!o_valid_q || out_ready) begin
        o_d       = new_slot;
        o_valid_d = 1'b1;
      end else begin
        s_d       = new_slot;
        s_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Counted at accept; a flushed accept never happened as far as the count goes.
  always_comb begin
    cnt_d = cnt_q;
    if (ill_cnt_clr) begin
      cnt_d = '0;
    end else if (accept && !flush && new_slot.illegal && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= '0;
      s_q       <= '0;
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      o_q       <= o_d;
      s_q       <= s_d;
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = o_valid_q;
  assign out_instr   = o_q.instr;
  assign out_imm     = o_q.imm;
  assign out_fmt     = o_q.fmt;
  assign out_illegal = o_q.illegal;
  assign ill_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 (2-bit counter) and an RV64 instance share one
// stimulus stream and are checked against an arithmetic decode model + queue.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, ill_cnt_clr;
  logic [31:0] in_instr;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_instr32, out_imm32;
  imm_fmt_e    out_fmt32;
  logic [1:0]  ill_cnt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt64;
  logic [15:0] ill_cnt64;

  imm_gen_pipe #(.XLEN(32), .ILL_CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
    .out_instr(out_instr32), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .ill_cnt(ill_cnt32), .ill_cnt_clr(ill_cnt_clr)
  );

  imm_gen_pipe #(.XLEN(64), .ILL_CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
    .out_instr(out_instr64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .ill_cnt(ill_cnt64), .ill_cnt_clr(ill_cnt_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    longint   v;
    imm_fmt_e f;
    logic     ill;
  } ref_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    imm_fmt_e    fmt32, fmt64;
    logic        ill32, ill64;
  } exp_t;

  exp_t exp_q[$];
  int   cnt32, cnt64;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] ops [16] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h13, 7'h1B,
                           7'h23, 7'h63, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F, 7'h2B};

  function automatic longint sext(input longint raw, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (raw >= half) ? raw - (half << 1) : raw;
  endfunction

  // Reference decode: fields assembled with weighted sums, then sign-folded.
  function automatic ref_t ref_dec(input logic [31:0] ins, input int xlen);
    ref_t r;
    int   op = int'(ins[6:0]);
    int   f3 = int'(ins[14:12]);
    bit   sh = (f3 == 1) || (f3 == 5);
    r.v = 0; r.f = FMT_NONE; r.ill = 1'b0;
    case (op)
      'h37, 'h17: begin r.v = sext(longint'(ins[31:12]) * 4096, 32); r.f = FMT_U; end
      'h6F: begin
        r.v = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                   longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
        r.f = FMT_J;
      end
      'h67, 'h03: begin r.v = sext(longint'(ins[31:20]), 12); r.f = FMT_I; end
      'h13: begin
        if (sh) begin
          r.v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
          r.f = FMT_SH;
        end else begin
          r.v = sext(longint'(ins[31:20]), 12); r.f = FMT_I;
        end
      end
      'h1B: begin
        if (xlen != 64) r.ill = 1'b1;
        else if (sh) begin r.v = longint'(ins[24:20]); r.f = FMT_SH; end
        else begin r.v = sext(longint'(ins[31:20]), 12); r.f = FMT_I; end
      end
      'h23: begin r.v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); r.f = FMT_S; end
      'h63: begin
        r.v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                   longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        r.f = FMT_B;
      end
      'h33, 'h0F, 'h73: ;
      'h3B: r.ill = (xlen != 64);
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] ins);
    exp_t e;
    ref_t a = ref_dec(ins, 32);
    ref_t b = ref_dec(ins, 64);
    e.instr = ins;
    e.imm32 = a.v[31:0]; e.fmt32 = a.f; e.ill32 = a.ill;
    e.imm64 = b.v;       e.fmt64 = b.f; e.ill64 = b.ill;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs, check outputs against the model, advance model over one edge
  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic fl = 1'b0, input logic clr = 1'b0, input logic r = 1'b0);
    logic rdy, acc;
    exp_t e;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl; ill_cnt_clr = clr; rst = r;
    #1;
    rdy = !r && (exp_q.size() < 2);
    check("in_ready32", 64'(in_ready32), 64'(rdy));
    check("in_ready64", 64'(in_ready64), 64'(rdy));
    check("out_valid32", 64'(out_valid32), 64'(exp_q.size() > 0));
    check("out_valid64", 64'(out_valid64), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("instr32", 64'(out_instr32), 64'(exp_q[0].instr));
      check("imm32", 64'(out_imm32), 64'(exp_q[0].imm32));
      check("fmt32", 64'(out_fmt32), 64'(exp_q[0].fmt32));
      check("ill32", 64'(out_illegal32), 64'(exp_q[0].ill32));
      check("instr64", 64'(out_instr64), 64'(exp_q[0].instr));
      check("imm64", out_imm64, exp_q[0].imm64);
      check("fmt64", 64'(out_fmt64), 64'(exp_q[0].fmt64));
      check("ill64", 64'(out_illegal64), 64'(exp_q[0].ill64));
    end
    check("ill_cnt32", 64'(ill_cnt32), 64'(cnt32));
    check("ill_cnt64", 64'(ill_cnt64), 64'(cnt64));
    if (r) begin
      exp_q.delete(); cnt32 = 0; cnt64 = 0;
    end else begin
      acc = v && rdy;
      e   = mk(ins);
      if (clr) begin
        cnt32 = 0; cnt64 = 0;
      end else if (acc && !fl) begin
        if (e.ill32 && cnt32 < 3)     cnt32++;
        if (e.ill64 && cnt64 < 65535) cnt64++;
      end
      if (fl) exp_q.delete();
      else begin
        if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] I_A = 32'h00100093;
  localparam logic [31:0] I_B = 32'h00200113;
  localparam logic [31:0] I_C = 32'h00300193;
  localparam logic [31:0] I_X = 32'h0000007F;

  initial begin
    logic [31:0] rnd, ins;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ill_cnt_clr = 1'b0; in_instr = '0;
    cnt32 = 0; cnt64 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset values
    check("rst_instr32", 64'(out_instr32), 64'h0);
    check("rst_imm32", 64'(out_imm32), 64'h0);
    check("rst_fmt32", 64'(out_fmt32), 64'(FMT_NONE));
    check("rst_ill32", 64'(out_illegal32), 64'h0);
    check("rst_imm64", out_imm64, 64'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // back-to-back RV32 mix
    drive(1'b1, 32'hFFF00093, 1'b1);
    check("addi_imm", 64'(out_imm32), 64'hFFFFFFFF);
    check("addi_fmt", 64'(out_fmt32), 64'(FMT_I));
    drive(1'b1, 32'h00309093, 1'b1);
    check("slli_imm", 64'(out_imm32), 64'h3);
    drive(1'b1, 32'h4050D093, 1'b1);
    check("srai_imm", 64'(out_imm32), 64'h5);
    check("srai_fmt", 64'(out_fmt32), 64'(FMT_SH));
    drive(1'b1, 32'hFE000EE3, 1'b1);
    check("beq_imm", 64'(out_imm32), 64'hFFFFFFFC);
    check("beq_fmt", 64'(out_fmt32), 64'(FMT_B));

    // RV64 forms
    drive(1'b1, 32'h800000B7, 1'b1);
    check("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    check("lui64_fmt", 64'(out_fmt64), 64'(FMT_U));
    drive(1'b1, 32'h03F09093, 1'b1);
    check("slli63_imm64", out_imm64, 64'd63);
    check("slli63_imm32", 64'(out_imm32), 64'd31);
    drive(1'b1, 32'hFFF0809B, 1'b1);
    check("addiw_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    check("addiw_fmt64", 64'(out_fmt64), 64'(FMT_I));
    check("addiw_ill32", 64'(out_illegal32), 64'h1);
    drive(1'b0, '0, 1'b1);

    // backpressure: O and S fill, third waits, then drains in order
    drive(1'b1, I_A, 1'b0);
    drive(1'b1, I_B, 1'b0);
    check("bp_stall_ready", 64'(in_ready32), 64'h0);
    drive(1'b1, I_C, 1'b0);
    drive(1'b1, I_C, 1'b1);
    check("bp_second", 64'(out_instr32), 64'(I_B));
    drive(1'b1, I_C, 1'b1);
    check("bp_third", 64'(out_instr32), 64'(I_C));
    drive(1'b0, '0, 1'b1);

    // illegal counting and saturation
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, I_X, 1'b1);
    check("ill_flag", 64'(out_illegal32), 64'h1);
    check("ill_imm", 64'(out_imm32), 64'h0);
    check("ill_cnt_one", 64'(ill_cnt32), 64'h1);
    repeat (4) drive(1'b1, I_X, 1'b1);
    check("ill_sat32", 64'(ill_cnt32), 64'h3);
    check("ill_cnt64_five", 64'(ill_cnt64), 64'h5);
    drive(1'b1, I_X, 1'b1, 1'b0, 1'b1);
    check("clr_prio", 64'(ill_cnt64), 64'h0);
    drive(1'b0, '0, 1'b1);

    // flush with O+S full, then flush racing an accept
    drive(1'b1, I_A, 1'b0);
    drive(1'b1, I_B, 1'b0);
    drive(1'b1, I_X, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid32), 64'h0);
    check("flush_ready", 64'(in_ready64), 64'h1);
    drive(1'b1, I_A, 1'b0);
    drive(1'b1, I_X, 1'b0, 1'b1);
    check("flush_drop_cnt", 64'(ill_cnt64), 64'h0);
    drive(1'b0, '0, 1'b1);

    // reset mid-transfer
    drive(1'b1, I_A, 1'b1);
    drive(1'b1, I_B, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_instr", 64'(out_instr64), 64'h0);
    check("rst_mid_imm", out_imm64, 64'h0);
    drive(1'b1, I_B, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, I_B, 1'b1);
    check("post_rst", 64'(out_instr32), 64'(I_B));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      ins = {rnd[31:7], ops[$urandom_range(0, 15)]};
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 127) == 0);
    end
    repeat (3) drive(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
